mbist_fail_logger: RTL and testbench
====================================

# mbist_fail_logger

Downstream consumer of the MBIST wrapper's `fail`, `fail_addr` and `done` outputs. Captures every failing address of a test run into a small FIFO, tagged with the active algorithm (`test_sel`). Keeps a saturating fail count, first-fail address and overflow flag. Presents a pass/fail verdict at end of run, and lets the host drain the log through a read handshake.

## Interface
- `ADDR_W`, 8, width of `fail_addr` and stored address
- `DEPTH`, 8, FIFO entries (power of two, ≥2)
- `CNT_W`, 16, width of saturating fail counter
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — reset; asynchronous, active-high
- `start` in 1 — same pulse fed to the MBIST controller; opens a new run
- `test_sel` in 2 — algorithm in use; stored as entry tag
- `fail` in 1 — MBIST fail strobe, one cycle per mismatching read
- `fail_addr` in ADDR_W — address of the failing read, valid with `fail`
- `done` in 1 — MBIST end-of-test (level)
- `rd_en` in 1 — host pops one log entry
- `rd_valid` out 1 — `rd_data` valid this cycle (one-cycle pulse)
- `rd_data` out 2+ADDR_W — `{tag[1:0], addr}`
- `empty` out 1 — FIFO empty
- `overflow` out 1 — sticky; a fail was dropped because the FIFO was full
- `fail_count` out CNT_W — fails this run, saturates at all-ones
- `first_fail_addr` out ADDR_W — address of first fail this run
- `result_valid` out 1 — run finished, verdict valid
- `pass` out 1 — `result_valid` and `fail_count == 0`

## Operation
- FSM states: IDLE, LOGGING, DONE.
  - IDLE → LOGGING on `start`.
  - LOGGING → DONE on `done` == 1.
  - DONE → LOGGING on `start`.
  - `start` in LOGGING restarts the run.
- Entering LOGGING clears the FIFO, `fail_count`, `first_fail_addr`, `overflow`, `result_valid` and `pass`. This includes a restart from LOGGING.
- Fails are accepted only in LOGGING. `fail` in IDLE or DONE is ignored.
  - In LOGGING, `fail` == 1 increments `fail_count`, saturating at 2^CNT_W−1 and never wrapping.
  - It writes `{test_sel, fail_addr}` into the FIFO if not full.
  - If full, the entry is dropped and `overflow` is set; the count still increments.
  - The first accepted fail of a run loads `first_fail_addr`.
- `fail` and `done` in the same cycle: the fail is logged, then the FSM moves to DONE. The verdict includes that fail.
- `start` and `fail` in the same cycle: the clear wins and the fail is discarded.
- Read: `rd_en` with `empty` == 0 pops the head; `rd_data`/`rd_valid` are registered, so they appear in the next cycle. `rd_en` while empty is ignored and `rd_valid` stays 0. Reads are allowed in every state.
- Simultaneous push and pop when full: both succeed, no overflow. When empty: the push lands, and the pop is ignored in that cycle.
- `rd_data` holds its last value when `rd_valid` is 0.

## Timing
- Reset values:
  - state IDLE
  - `rd_valid` 0, `rd_data` 0
  - `empty` 1, `overflow` 0
  - `fail_count` 0, `first_fail_addr` 0
  - `result_valid` 0, `pass` 0
- `fail` sampled at edge N: `fail_count` and `empty` update after edge N.
- `done` sampled at edge N: `result_valid` and `pass` are high after edge N and stay high until the next `start` or `rst`.
- Pop latency is one cycle: `rd_en` at edge N gives `rd_valid` after edge N, for exactly one cycle.
- `rst` mid-run aborts immediately, back to the reset values. The FIFO contents are discarded.
- Back-to-back fails every cycle are supported at full throughput up to DEPTH entries.

## Structure
- Package `mbist_log_pkg`:
  - state enum (`IDLE`, `LOGGING`, `DONE`)
  - entry struct `{tag, addr}`
  - defaults for `ADDR_W`, `DEPTH`, `CNT_W`
- Sub-module `mbist_log_fifo`: synchronous FIFO with the parameters above. It provides clear, push, pop, full, empty and a registered read port.
- FSM, counters and verdict logic live in the top.

## Test plan
- Clean run: `start`, 100 cycles with no `fail`, then `done` → `result_valid`=1, `pass`=1, `fail_count`=0, `empty`=1.
- Three fails:
  - Stimulus: `test_sel`=2, fails at addrs 0x05, 0x40, 0xFF, then `done`.
  - Expect `fail_count`=3, `first_fail_addr`=0x05, `pass`=0.
  - Draining with 3 `rd_en` pulses gives `rd_data` 0x205, 0x240, 0x2FF; `empty`=1 after.
- Overflow: 10 consecutive fails with DEPTH=8 → 8 entries stored, `overflow`=1, `fail_count`=10. The 9th `rd_en` gives no `rd_valid`.
- Corner cases: `fail` in the same cycle as `done` is logged (`fail_count`=1, `pass`=0). `fail` in the same cycle as `start` is dropped (`fail_count`=0).
- Full push+pop: with the FIFO full, `fail` and `rd_en` in the same cycle → still full, `overflow`=0, head entry returned.
- `rst` asserted mid-run after 4 fails → all outputs at reset values on the next sample. A later `start` and `done` give `pass`=1.

Source files
------------

// File: rtl/mbist_fail_logger_pkg.sv
// mbist_log_pkg: shared types and default sizes for the MBIST fail logger
package mbist_log_pkg;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_CNT_W  = 16;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOGGING = 2'd1,
        DONE    = 2'd2
    } state_e;
    typedef struct packed {
        logic [1:0]            tag;
        logic [DEF_ADDR_W-1:0] addr;
    } entry_t;
endpackage

// File: rtl/mbist_fail_logger_if.sv
// mbist_fail_logger_if: MBIST result inputs plus host log-drain port
interface mbist_fail_logger_if
    import mbist_log_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic              start;
    logic [1:0]        test_sel;
    logic              fail;
    logic [ADDR_W-1:0] fail_addr;
    logic              done;
    logic              rd_en;
    logic              rd_valid;
    logic [ADDR_W+1:0] rd_data;
    logic              empty;
    logic              overflow;
    logic [CNT_W-1:0]  fail_count;
    logic [ADDR_W-1:0] first_fail_addr;
    logic              result_valid;
    logic              pass;
    modport master (
        output start, test_sel, fail, fail_addr, done, rd_en,
        input  rd_valid, rd_data, empty, overflow, fail_count, first_fail_addr, result_valid, pass
    );
    modport slave (
        input  start, test_sel, fail, fail_addr, done, rd_en,
        output rd_valid, rd_data, empty, overflow, fail_count, first_fail_addr, result_valid, pass
    );
endinterface

// File: rtl/mbist_fail_logger_fifo.sv
// mbist_log_fifo: clearable synchronous FIFO with a registered read port
module mbist_log_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic         rd_valid,
    output logic [W-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic         rd_valid_q, rd_valid_d;
    logic [W-1:0] rd_data_q, rd_data_d;
    logic         pop_ok, push_ok;
    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // a pop frees the slot this cycle, so a push against a full FIFO may land
    assign pop_ok  = pop && !empty && !clr;
    assign push_ok = push && !clr && (!full || pop_ok);
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    always_comb begin
        wr_ptr_d   = clr ? '0 : wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d   = clr ? '0 : rd_ptr_q + (AW+1)'(pop_ok);
        rd_valid_d = pop_ok;
        rd_data_d  = pop_ok ? mem_q[rd_ptr_q[AW-1:0]] : rd_data_q;
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end
endmodule

// File: rtl/mbist_fail_logger.sv
// mbist_fail_logger: logs MBIST failing addresses per run and reports a verdict
module mbist_fail_logger
    import mbist_log_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input logic                clk,
    input logic                rst,
    mbist_fail_logger_if.slave bus
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic              ovf_q, ovf_d, res_q, res_d, pass_q, pass_d;
    logic              fifo_full, log_fail, finish;
    // start outranks any fail or done seen in the same cycle
    assign log_fail = (state_q == LOGGING) && bus.fail && !bus.start;
    assign finish   = (state_q == LOGGING) && bus.done && !bus.start;
    always_comb begin
        state_d = bus.start ? LOGGING : finish ? DONE : state_q;
        cnt_d   = bus.start ? '0 : (log_fail && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        first_d = bus.start ? '0 : (log_fail && cnt_q == '0) ? bus.fail_addr : first_q;
        ovf_d   = bus.start ? 1'b0 : ovf_q | (log_fail && fifo_full && !bus.rd_en);
        res_d   = bus.start ? 1'b0 : finish ? 1'b1 : res_q;
        pass_d  = bus.start ? 1'b0 : finish ? (cnt_d == '0) : pass_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            first_q <= '0;
            ovf_q   <= 1'b0;
            res_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            ovf_q   <= ovf_d;
            res_q   <= res_d;
            pass_q  <= pass_d;
        end
    end
    mbist_log_fifo #(.W(ADDR_W + 2), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.start),
        .push     (log_fail),
        .pop      (bus.rd_en),
        .din      ({bus.test_sel, bus.fail_addr}),
        .full     (fifo_full),
        .empty    (bus.empty),
        .rd_valid (bus.rd_valid),
        .rd_data  (bus.rd_data)
    );
    assign bus.overflow        = ovf_q;
    assign bus.fail_count      = cnt_q;
    assign bus.first_fail_addr = first_q;
    assign bus.result_valid    = res_q;
    assign bus.pass            = pass_q;
endmodule

// File: tb/tb_mbist_fail_logger.sv
// tb_mbist_fail_logger: directed + random checks against a queue-based log model
module tb_mbist_fail_logger;
    import mbist_log_pkg::*;
    // narrow counter so saturation is reachable in a short run
    localparam int CNT_W = 5;
    localparam int DEPTH = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mbist_fail_logger_if #(.ADDR_W(8), .CNT_W(CNT_W)) bus ();
    mbist_fail_logger #(.ADDR_W(8), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
    int     n_chk = 0;
    int     n_pass = 0;
    entry_t q[$];
    int     m_cnt;
    logic [7:0] m_first;
    logic   m_ovf, m_run, m_res, m_pass, m_rv;
    logic [9:0] m_rd;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask
    task automatic check_all();
        check("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
        check("rd_data", 32'(bus.rd_data), 32'(m_rd));
        check("empty", 32'(bus.empty), 32'(q.size() == 0));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("fail_count", 32'(bus.fail_count), 32'(m_cnt));
        check("first_fail", 32'(bus.first_fail_addr), 32'(m_first));
        check("result_valid", 32'(bus.result_valid), 32'(m_res));
        check("pass", 32'(bus.pass), 32'(m_pass));
    endtask
    task automatic model_reset();
        q.delete();
        m_cnt = 0; m_first = '0; m_ovf = 0; m_run = 0; m_res = 0; m_pass = 0; m_rv = 0; m_rd = '0;
    endtask
    task automatic step(input logic s, input logic [1:0] sel, input logic f, input logic [7:0] a,
                        input logic d, input logic r);
        entry_t e;
        @(negedge clk);
        bus.start = s; bus.test_sel = sel; bus.fail = f; bus.fail_addr = a; bus.done = d; bus.rd_en = r;
        m_rv = 0;
        if (r && q.size() > 0 && !s) begin
            e = q.pop_front();
            m_rv = 1;
            m_rd = {e.tag, e.addr};
        end
        if (s) begin
            q.delete();
            m_cnt = 0; m_first = '0; m_ovf = 0; m_res = 0; m_pass = 0; m_run = 1;
        end else if (m_run) begin
            if (f) begin
                if (m_cnt == 0) m_first = a;
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                e.tag = sel; e.addr = a;
                if (q.size() < DEPTH) q.push_back(e);
                else m_ovf = 1;
            end
            if (d) begin
                m_run = 0; m_res = 1; m_pass = (m_cnt == 0);
            end
        end
        @(posedge clk);
        #1 check_all();
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 2'd0, 0, 8'h00, 0, 0);
    endtask
    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) step(0, 2'd0, 0, 8'h00, 0, 1);
    endtask
    task automatic fails(input int n, input logic [1:0] sel);
        for (int i = 0; i < n; i++) step(0, sel, 1, 8'($urandom), 0, 0);
    endtask
    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        @(posedge clk);
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        bus.start = 0; bus.test_sel = 0; bus.fail = 0; bus.fail_addr = 0; bus.done = 0; bus.rd_en = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
        step(1, 2'd0, 0, 8'h00, 0, 0);
        idle(100);
        step(0, 2'd0, 0, 8'h00, 1, 0);
        idle(2);
        step(1, 2'd2, 0, 8'h00, 0, 0);
        step(0, 2'd2, 1, 8'h05, 0, 0);
        step(0, 2'd2, 1, 8'h40, 0, 0);
        idle(1);
        step(0, 2'd2, 1, 8'hFF, 0, 0);
        step(0, 2'd2, 0, 8'h00, 1, 0);
        pop_n(3);
        check("drain_last", 32'(bus.rd_data), 32'h2FF);
        pop_n(1);
        step(1, 2'd1, 0, 8'h00, 0, 0);
        fails(10, 2'd1);
        step(0, 2'd1, 0, 8'h00, 1, 0);
        check("ovf_count", 32'(bus.fail_count), 32'd10);
        pop_n(9);
        step(1, 2'd3, 0, 8'h00, 0, 0);
        step(0, 2'd3, 1, 8'h33, 1, 0);
        step(1, 2'd0, 0, 8'h00, 0, 0);
        step(1, 2'd0, 1, 8'h44, 0, 0);
        idle(1);
        fails(8, 2'd2);
        step(0, 2'd1, 1, 8'h99, 0, 1);
        step(0, 2'd0, 0, 8'h00, 0, 0);
        pop_n(8);
        step(1, 2'd0, 0, 8'h00, 0, 0);
        fails(35, 2'd3);
        step(0, 2'd0, 0, 8'h00, 1, 0);
        step(1, 2'd0, 0, 8'h00, 0, 0);
        fails(4, 2'd1);
        async_reset();
        step(1, 2'd0, 0, 8'h00, 0, 0);
        step(0, 2'd0, 0, 8'h00, 1, 0);
        check("post_rst_pass", 32'(bus.pass), 32'd1);
        for (int i = 0; i < 3000; i++) begin
            logic s;
            s = ($urandom_range(0, 99) < 3);
            step(s, 2'($urandom), ($urandom_range(0, 99) < 35), 8'($urandom),
                 ($urandom_range(0, 99) < 3), !s && ($urandom_range(0, 99) < 25));
            if (i == 1500) async_reset();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
